// File: rtl/mem_access_stage.sv
// Memory stage plus M/W pipeline register of the 5-stage RISC-V core.
//
// Turns the M_* bundle into a single req/ack bus transaction for loads and stores
// (word-aligned address, byte-lane enables, replicated store data), aligns and
// extends load data, and registers the writeback bundle. While a bus access is
// outstanding, stall freezes the upstream pipeline and W receives bubbles, so each
// instruction writes back exactly once.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   M_*                         execute/memory pipeline register bundle (inputs)
//   mem_rdata, mem_ack          bus read word and completion strobe
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be           registered bus request, held stable until ack
//   stall                       combinational freeze for PC/F/D/E/M registers
//   W_*                         registered writeback bundle
//   misalign_err, bus_err       one-cycle error pulses (misaligned op, bus timeout)
module mem_access_stage #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  M_RegWrite,
   input  logic                  M_mem_write,
   input  logic [1:0]            M_type_control,
   input  logic                  M_sign_ext_flag,
   input  logic [1:0]            M_result_src,
   input  logic [DATA_WIDTH-1:0] M_alu_result,
   input  logic [DATA_WIDTH-1:0] M_write_data,
   input  logic [DATA_WIDTH-1:0] M_pc_out4,
   input  logic [4:0]            M_rd,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   output logic                  stall,
   output logic                  W_RegWrite,
   output logic [1:0]            W_result_src,
   output logic [DATA_WIDTH-1:0] W_alu_result,
   output logic [DATA_WIDTH-1:0] W_read_data,
   output logic [DATA_WIDTH-1:0] W_pc_out4,
   output logic [4:0]            W_rd,
   output logic                  misalign_err,
   output logic                  bus_err
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StAccess} state_t;

   state_t r_state;
   state_t w_state_d;

   // Registered bus outputs
   logic                  r_req, w_req_d;
   logic                  r_we, w_we_d;
   logic [DATA_WIDTH-1:0] r_addr, w_addr_d;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
   logic [3:0]            r_be, w_be_d;
   logic [CntW-1:0]       r_cnt, w_cnt_d;

   // Registered writeback bundle and error pulses
   logic                  r_w_regwrite, w_w_regwrite_d;
   logic [1:0]            r_w_result_src, w_w_result_src_d;
   logic [DATA_WIDTH-1:0] r_w_alu, w_w_alu_d;
   logic [DATA_WIDTH-1:0] r_w_rdata, w_w_rdata_d;
   logic [DATA_WIDTH-1:0] r_w_pc4, w_w_pc4_d;
   logic [4:0]            r_w_rd, w_w_rd_d;
   logic                  r_misalign, w_misalign_d;
   logic                  r_bus_err, w_bus_err_d;

   // Decode of the M bundle
   logic                  w_is_load;
   logic                  w_mem_op;
   logic [1:0]            w_off;
   logic                  w_misaligned;
   logic                  w_timeout;
   logic                  w_stall;
   logic [3:0]            w_be_calc;
   logic [DATA_WIDTH-1:0] w_wdata_calc;
   logic [7:0]            w_lane_b;
   logic [15:0]           w_lane_h;
   logic [DATA_WIDTH-1:0] w_load_data;

   assign w_is_load    = (M_result_src == 2'b01) && !M_mem_write;
   assign w_mem_op     = w_is_load || M_mem_write;
   assign w_off        = M_alu_result[1:0];
   // Type 11 is treated as word, so any type with bit 1 set needs off == 00
   assign w_misaligned = ((M_type_control == 2'b01) && w_off[0]) ||
                         (M_type_control[1] && (w_off != 2'b00));
   assign w_timeout    = (TIMEOUT != 0) && (r_cnt == CntLast);

   // Byte-lane enables and store replication; loads reuse the same enables
   always_comb begin
      w_be_calc    = 4'b1111;
      w_wdata_calc = M_write_data;
      unique case (M_type_control)
         2'b00: begin
            w_be_calc    = 4'b0001 << w_off;
            w_wdata_calc = {4{M_write_data[7:0]}};
         end
         2'b01: begin
            w_be_calc    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata_calc = {2{M_write_data[15:0]}};
         end
         default: begin
            w_be_calc    = 4'b1111;
            w_wdata_calc = M_write_data;
         end
      endcase
   end

   // Load lane selection and extension. M is frozen by stall during ACCESS, so the
   // offset and type seen at ack are those of the issuing instruction.
   assign w_lane_b = mem_rdata[{w_off, 3'b000} +: 8];
   assign w_lane_h = mem_rdata[{w_off[1], 4'b0000} +: 16];

   always_comb begin
      w_load_data = mem_rdata;
      unique case (M_type_control)
         2'b00:   w_load_data = M_sign_ext_flag ? {{24{w_lane_b[7]}}, w_lane_b}
                                                : {24'b0, w_lane_b};
         2'b01:   w_load_data = M_sign_ext_flag ? {{16{w_lane_h[15]}}, w_lane_h}
                                                : {16'b0, w_lane_h};
         default: w_load_data = mem_rdata;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // FSM: next-state logic
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_mem_op && !w_misaligned) w_state_d = StAccess;
         end
         StAccess: begin
            if (mem_ack || w_timeout) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // FSM: outputs (stall plus next values for the bus and writeback registers)
   always_comb begin
      w_stall          = 1'b0;
      w_req_d          = r_req;
      w_we_d           = r_we;
      w_addr_d         = r_addr;
      w_wdata_d        = r_wdata;
      w_be_d           = r_be;
      w_cnt_d          = '0;
      w_misalign_d     = 1'b0;
      w_bus_err_d      = 1'b0;
      // Bubble unless an instruction completes this cycle
      w_w_regwrite_d   = 1'b0;
      w_w_result_src_d = 2'b00;
      w_w_alu_d        = '0;
      w_w_rdata_d      = '0;
      w_w_pc4_d        = '0;
      w_w_rd_d         = 5'd0;

      unique case (r_state)
         StIdle: begin
            if (w_mem_op) begin
               if (w_misaligned) begin
                  w_misalign_d = 1'b1;
               end else begin
                  w_stall   = 1'b1;
                  w_req_d   = 1'b1;
                  w_we_d    = M_mem_write;
                  w_addr_d  = {M_alu_result[DATA_WIDTH-1:2], 2'b00};
                  w_wdata_d = w_wdata_calc;
                  w_be_d    = w_be_calc;
               end
            end else begin
               w_w_regwrite_d   = M_RegWrite;
               w_w_result_src_d = M_result_src;
               w_w_alu_d        = M_alu_result;
               w_w_pc4_d        = M_pc_out4;
               w_w_rd_d         = M_rd;
            end
         end
         StAccess: begin
            if (mem_ack) begin
               w_req_d          = 1'b0;
               w_we_d           = 1'b0;
               w_w_regwrite_d   = M_RegWrite;
               w_w_result_src_d = M_result_src;
               w_w_alu_d        = M_alu_result;
               w_w_rdata_d      = w_is_load ? w_load_data : '0;
               w_w_pc4_d        = M_pc_out4;
               w_w_rd_d         = M_rd;
            end else if (w_timeout) begin
               // Abort: the instruction is dropped and W gets a bubble
               w_req_d     = 1'b0;
               w_we_d      = 1'b0;
               w_bus_err_d = 1'b1;
            end else begin
               w_stall = 1'b1;
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         default: begin
            w_req_d = 1'b0;
            w_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req          <= 1'b0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_be           <= 4'b0000;
         r_cnt          <= '0;
         r_w_regwrite   <= 1'b0;
         r_w_result_src <= 2'b00;
         r_w_alu        <= '0;
         r_w_rdata      <= '0;
         r_w_pc4        <= '0;
         r_w_rd         <= 5'd0;
         r_misalign     <= 1'b0;
         r_bus_err      <= 1'b0;
      end else begin
         r_req          <= w_req_d;
         r_we           <= w_we_d;
         r_addr         <= w_addr_d;
         r_wdata        <= w_wdata_d;
         r_be           <= w_be_d;
         r_cnt          <= w_cnt_d;
         r_w_regwrite   <= w_w_regwrite_d;
         r_w_result_src <= w_w_result_src_d;
         r_w_alu        <= w_w_alu_d;
         r_w_rdata      <= w_w_rdata_d;
         r_w_pc4        <= w_w_pc4_d;
         r_w_rd         <= w_w_rd_d;
         r_misalign     <= w_misalign_d;
         r_bus_err      <= w_bus_err_d;
      end
   end

   assign stall        = w_stall;
   assign mem_req      = r_req;
   assign mem_we       = r_we;
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign mem_be       = r_be;
   assign W_RegWrite   = r_w_regwrite;
   assign W_result_src = r_w_result_src;
   assign W_alu_result = r_w_alu;
   assign W_read_data  = r_w_rdata;
   assign W_pc_out4    = r_w_pc4;
   assign W_rd         = r_w_rd;
   assign misalign_err = r_misalign;
   assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions push their expected
// bus request / writeback / error events; a monitor pops and compares as they appear.
module tb_mem_access_stage;

   localparam int TO = 4;
   localparam int KReq = 0;
   localparam int KW   = 1;
   localparam int KMis = 2;
   localparam int KBus = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        M_RegWrite, M_mem_write, M_sign_ext_flag;
   logic [1:0]  M_type_control, M_result_src;
   logic [31:0] M_alu_result, M_write_data, M_pc_out4;
   logic [4:0]  M_rd;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        mem_req, mem_we, stall;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        W_RegWrite;
   logic [1:0]  W_result_src;
   logic [31:0] W_alu_result, W_read_data, W_pc_out4;
   logic [4:0]  W_rd;
   logic        misalign_err, bus_err;

   typedef struct {
      int           kind;
      logic [127:0] val;
   } exp_t;

   exp_t         sb[$];
   int           n_pass = 0;
   int           n_total = 0;
   logic         prev_req = 1'b0;
   logic [127:0] prev_bus = '0;

   mem_access_stage #(
      .DATA_WIDTH(32),
      .TIMEOUT   (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .M_RegWrite     (M_RegWrite),
      .M_mem_write    (M_mem_write),
      .M_type_control (M_type_control),
      .M_sign_ext_flag(M_sign_ext_flag),
      .M_result_src   (M_result_src),
      .M_alu_result   (M_alu_result),
      .M_write_data   (M_write_data),
      .M_pc_out4      (M_pc_out4),
      .M_rd           (M_rd),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_be         (mem_be),
      .stall          (stall),
      .W_RegWrite     (W_RegWrite),
      .W_result_src   (W_result_src),
      .W_alu_result   (W_alu_result),
      .W_read_data    (W_read_data),
      .W_pc_out4      (W_pc_out4),
      .W_rd           (W_rd),
      .misalign_err   (misalign_err),
      .bus_err        (bus_err)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] pack_req(input logic we, input logic [3:0] be,
                                             input logic [31:0] addr, input logic [31:0] wd);
      return {59'b0, we, be, addr, wd};
   endfunction

   function automatic logic [127:0] pack_w(input logic rw, input logic [1:0] rs,
                                           input logic [31:0] alu, input logic [31:0] rdat,
                                           input logic [31:0] pc4, input logic [4:0] rd);
      return {24'b0, rw, rs, alu, rdat, pc4, rd};
   endfunction

   function automatic void push(input int k, input logic [127:0] v);
      sb.push_back('{kind: k, val: v});
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h", nm, act, req);
   endtask

   task automatic expect_out(input int kind, input logic [127:0] act, input string nm);
      exp_t e;
      n_total++;
      if (sb.size() == 0) begin
         $display("FAIL %s: unexpected output %h with empty scoreboard", nm, act);
      end else begin
         e = sb.pop_front();
         if (e.kind == kind && e.val === act) n_pass++;
         else $display("FAIL %s: got kind %0d value %h, required kind %0d value %h",
                       nm, kind, act, e.kind, e.val);
      end
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (mem_req && !prev_req)
            expect_out(KReq, pack_req(mem_we, mem_be, mem_addr, mem_wdata), "bus_request");
         if (mem_req && prev_req)
            chk("bus_hold", pack_req(mem_we, mem_be, mem_addr, mem_wdata), prev_bus);
         if (|{W_RegWrite, W_result_src, W_alu_result, W_read_data, W_pc_out4, W_rd})
            expect_out(KW, pack_w(W_RegWrite, W_result_src, W_alu_result, W_read_data,
                                  W_pc_out4, W_rd), "writeback");
         if (misalign_err) expect_out(KMis, 128'd0, "misalign_err");
         if (bus_err) expect_out(KBus, 128'd0, "bus_err");
         prev_req = mem_req;
         prev_bus = pack_req(mem_we, mem_be, mem_addr, mem_wdata);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_m(input logic rw, input logic mw, input logic [1:0] tc,
                          input logic sx, input logic [1:0] rs, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc4,
                          input logic [4:0] rd);
      M_RegWrite      = rw;
      M_mem_write     = mw;
      M_type_control  = tc;
      M_sign_ext_flag = sx;
      M_result_src    = rs;
      M_alu_result    = alu;
      M_write_data    = wd;
      M_pc_out4       = pc4;
      M_rd            = rd;
   endtask

   task automatic drive_idle();
      drive_m(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
   endtask

   // Holds the instruction in M until stall drops; waits < 0 means never ack.
   task automatic run_op(input string nm, input logic rw, input logic mw,
                         input logic [1:0] tc, input logic sx, input logic [1:0] rs,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4, input logic [4:0] rd,
                         input logic [31:0] rdata, input int waits,
                         input int exp_stall, input int exp_req);
      int c = 0;
      int st = 0;
      int rq = 0;
      bit done = 1'b0;
      @(posedge clk);
      #1;
      drive_m(rw, mw, tc, sx, rs, alu, wd, pc4, rd);
      mem_rdata = rdata;
      while (!done && c < 40) begin
         mem_ack = (waits >= 0) && (c == waits + 1);
         @(negedge clk);
         if (stall) st++;
         if (mem_req) rq++;
         if (!stall) begin
            done = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
         c++;
      end
      @(posedge clk);
      #1;
      drive_idle();
      mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      chk({nm, "_stall_cycles"}, st, exp_stall);
      chk({nm, "_req_cycles"}, rq, exp_req);
   endtask

   initial begin
      rst       = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_bus", {mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall,
                        misalign_err, bus_err}, 128'd0);
      chk("reset_wb", pack_w(W_RegWrite, W_result_src, W_alu_result, W_read_data,
                             W_pc_out4, W_rd), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ALU op passes straight through
      push(KW, pack_w(1'b1, 2'b00, 32'h1234, 32'h0, 32'h3004, 5'd5));
      run_op("alu", 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'h1234, 32'h0, 32'h3004, 5'd5,
             32'h0, 0, 0, 0);

      // JAL-style result_src 10 is not a memory op
      push(KW, pack_w(1'b1, 2'b10, 32'hABC, 32'h0, 32'hC004, 5'd1));
      run_op("jal", 1'b1, 1'b0, 2'b10, 1'b0, 2'b10, 32'hABC, 32'h0, 32'hC004, 5'd1,
             32'h0, 0, 0, 0);

      // LB sign-extend, top byte
      push(KReq, pack_req(1'b0, 4'b1000, 32'h100, 32'h0));
      push(KW, pack_w(1'b1, 2'b01, 32'h103, 32'hFFFF_FF80, 32'h1004, 5'd7));
      run_op("lb", 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 32'h103, 32'h0, 32'h1004, 5'd7,
             32'h80FF_0000, 0, 1, 1);

      // SH upper half, three wait cycles
      push(KReq, pack_req(1'b1, 4'b1100, 32'h20, 32'hBEEF_BEEF));
      push(KW, pack_w(1'b0, 2'b00, 32'h22, 32'h0, 32'h2004, 5'd0));
      run_op("sh", 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 32'h22, 32'h0000_BEEF, 32'h2004, 5'd0,
             32'h0, 3, 4, 4);

      // LHU misaligned
      push(KMis, 128'd0);
      run_op("lhu_mis", 1'b1, 1'b0, 2'b01, 1'b0, 2'b01, 32'h41, 32'h0, 32'h4004, 5'd9,
             32'h0, 0, 0, 0);

      // LW with no ack times out after TO access cycles
      push(KReq, pack_req(1'b0, 4'b1111, 32'h200, 32'h0));
      push(KBus, 128'd0);
      run_op("lw_timeout", 1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 32'h200, 32'h0, 32'h5004, 5'd4,
             32'h0, -1, TO, TO);

      // LH sign-extend, upper half
      push(KReq, pack_req(1'b0, 4'b1100, 32'h300, 32'h0));
      push(KW, pack_w(1'b1, 2'b01, 32'h302, 32'hFFFF_8001, 32'h6004, 5'd10));
      run_op("lh", 1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 32'h302, 32'h0, 32'h6004, 5'd10,
             32'h8001_7FFF, 0, 1, 1);

      // LBU byte 1, one wait cycle
      push(KReq, pack_req(1'b0, 4'b0010, 32'h400, 32'h0));
      push(KW, pack_w(1'b1, 2'b01, 32'h401, 32'h0000_0056, 32'h7004, 5'd11));
      run_op("lbu", 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 32'h401, 32'h0, 32'h7004, 5'd11,
             32'h1234_56F0, 1, 2, 2);

      // LW, two wait cycles
      push(KReq, pack_req(1'b0, 4'b1111, 32'h504, 32'h0));
      push(KW, pack_w(1'b1, 2'b01, 32'h504, 32'hDEAD_BEEF, 32'h8004, 5'd12));
      run_op("lw", 1'b1, 1'b0, 2'b10, 1'b1, 2'b01, 32'h504, 32'h0, 32'h8004, 5'd12,
             32'hDEAD_BEEF, 2, 3, 3);

      // SB byte 1 replicates the low byte
      push(KReq, pack_req(1'b1, 4'b0010, 32'h600, 32'hA5A5_A5A5));
      push(KW, pack_w(1'b0, 2'b00, 32'h601, 32'h0, 32'h9004, 5'd0));
      run_op("sb", 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'h601, 32'h1234_56A5, 32'h9004, 5'd0,
             32'h0, 0, 1, 1);

      // SW misaligned
      push(KMis, 128'd0);
      run_op("sw_mis", 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 32'h702, 32'h1111_2222, 32'hE004,
             5'd0, 32'h0, 0, 0, 0);

      // Type 11 behaves as a word load
      push(KReq, pack_req(1'b0, 4'b1111, 32'h808, 32'h0));
      push(KW, pack_w(1'b1, 2'b01, 32'h808, 32'hCAFE_F00D, 32'hA004, 5'd13));
      run_op("lw_t11", 1'b1, 1'b0, 2'b11, 1'b0, 2'b01, 32'h808, 32'h0, 32'hA004, 5'd13,
             32'hCAFE_F00D, 0, 1, 1);

      // Reset in the second ACCESS cycle of a load aborts without an error pulse
      push(KReq, pack_req(1'b0, 4'b1111, 32'h700, 32'h0));
      @(posedge clk);
      #1;
      drive_m(1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 32'h700, 32'h0, 32'hD004, 5'd6);
      mem_ack = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_abort_req", mem_req, 1'b0);
      chk("rst_abort_wb", pack_w(W_RegWrite, W_result_src, W_alu_result, W_read_data,
                                 W_pc_out4, W_rd), 128'd0);
      @(posedge clk);
      #1;
      drive_idle();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (TO + 4) @(posedge clk);

      // Ack while idle is ignored
      #1;
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk("ack_idle_req", {mem_req, stall}, 2'b00);

      // LB zero offset after the reset abort: FSM must be back in IDLE
      push(KReq, pack_req(1'b0, 4'b0001, 32'h900, 32'h0));
      push(KW, pack_w(1'b1, 2'b01, 32'h900, 32'hFFFF_FFFF, 32'hB004, 5'd14));
      run_op("lb_after_rst", 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 32'h900, 32'h0, 32'hB004,
             5'd14, 32'h0000_00FF, 0, 1, 1);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
